// File: rtl/counter_scheduler.sv
// counter_scheduler: two-requester round-robin scheduler that owns a shared
// 4-bit up-counter. A granted requester gets one counting run from 0 up to
// the target it presented at grant time, followed by a one-cycle done pulse.
// Dropping the request mid-run aborts the run without a done pulse.
module counter_scheduler (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic [3:0] tgt0,
    input  logic [3:0] tgt1,
    output logic [1:0] gnt,
    output logic [3:0] q,
    output logic       busy,
    output logic [1:0] done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t     state_r;
    logic [3:0] tgt_r;
    logic [3:0] q_r;
    logic [1:0] gnt_r;
    logic [1:0] done_r;
    logic       busy_r;
    logic       ptr_r;    // requester favoured on a tie
    logic       owner_r;  // index of the requester currently served

    logic       win_s;
    logic [3:0] win_tgt_s;
    logic       owner_req_s;

    // Converts a requester index to its one-hot grant/done vector.
    function automatic logic [1:0] onehot(input logic idx);
        onehot = idx ? 2'b10 : 2'b01;
    endfunction

    // Round-robin winner among the current requests and the target it brings.
    always_comb begin
        win_s       = 1'b0;
        win_tgt_s   = tgt0;
        owner_req_s = req[owner_r];
        if (req == 2'b11) begin
            win_s = ptr_r;
        end else begin
            win_s = req[1];
        end
        if (win_s) begin
            win_tgt_s = tgt1;
        end else begin
            win_tgt_s = tgt0;
        end
    end

    // Scheduler FSM; all outputs are registered here.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
            tgt_r   <= 4'd0;
            q_r     <= 4'd0;
            gnt_r   <= 2'b00;
            done_r  <= 2'b00;
            busy_r  <= 1'b0;
            ptr_r   <= 1'b0;
            owner_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    done_r <= 2'b00;
                    if (req != 2'b00) begin
                        owner_r <= win_s;
                        tgt_r   <= win_tgt_s;
                        q_r     <= 4'd0;
                        gnt_r   <= onehot(win_s);
                        busy_r  <= 1'b1;
                        state_r <= COUNT;
                    end else begin
                        gnt_r   <= 2'b00;
                        busy_r  <= 1'b0;
                        state_r <= IDLE;
                    end
                end
                COUNT: begin
                    if (!owner_req_s) begin
                        // Abort: the other requester is favoured next.
                        q_r     <= 4'd0;
                        gnt_r   <= 2'b00;
                        done_r  <= 2'b00;
                        busy_r  <= 1'b0;
                        ptr_r   <= ~owner_r;
                        state_r <= IDLE;
                    end else if (q_r == tgt_r) begin
                        done_r  <= onehot(owner_r);
                        state_r <= DONE;
                    end else begin
                        q_r     <= q_r + 4'd1;
                        state_r <= COUNT;
                    end
                end
                DONE: begin
                    // q keeps the final count while idle.
                    gnt_r   <= 2'b00;
                    done_r  <= 2'b00;
                    busy_r  <= 1'b0;
                    ptr_r   <= ~owner_r;
                    state_r <= IDLE;
                end
                default: begin
                    q_r     <= 4'd0;
                    gnt_r   <= 2'b00;
                    done_r  <= 2'b00;
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign gnt  = gnt_r;
    assign q    = q_r;
    assign busy = busy_r;
    assign done = done_r;

endmodule

// File: tb/tb_counter_scheduler.sv
// Bench for counter_scheduler: directed scenarios with literal expectations
// plus a randomized phase, all outputs compared every cycle against a
// transaction-level model (grant time, target, elapsed edges).
module tb_counter_scheduler;

    logic       clk;
    logic       rst;
    logic [1:0] req;
    logic [3:0] tgt0;
    logic [3:0] tgt1;
    logic [1:0] gnt;
    logic [3:0] q;
    logic       busy;
    logic [1:0] done;

    int errors = 0;
    int checks = 0;

    counter_scheduler dut (
        .clk  (clk),
        .rst  (rst),
        .req  (req),
        .tgt0 (tgt0),
        .tgt1 (tgt1),
        .gnt  (gnt),
        .q    (q),
        .busy (busy),
        .done (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a run is described by its owner, target and edges since grant.
    bit         m_active = 0;
    int         m_owner  = 0;
    int         m_tgt    = 0;
    int         m_j      = 0;
    int         m_last   = 1;   // last served; 1 after reset so 0 wins ties
    logic [1:0] e_gnt    = 2'b00;
    logic [3:0] e_q      = 4'd0;
    logic [1:0] e_done   = 2'b00;
    logic       e_busy   = 1'b0;

    task automatic finish_run();
        m_active = 0;
        m_last   = m_owner;
        e_gnt    = 2'b00;
        e_done   = 2'b00;
        e_busy   = 1'b0;
    endtask

    // Advance the model on each rising edge, then compare just after it.
    always @(posedge clk) begin
        if (!rst) begin
            m_active = 0;
            m_last   = 1;
            e_gnt = 2'b00; e_q = 4'd0; e_done = 2'b00; e_busy = 1'b0;
        end else if (!m_active) begin
            e_done = 2'b00;
            if (req != 2'b00) begin
                if (req == 2'b11) m_owner = 1 - m_last;
                else              m_owner = req[1] ? 1 : 0;
                m_tgt    = (m_owner == 1) ? int'(tgt1) : int'(tgt0);
                m_j      = 0;
                m_active = 1;
                e_gnt    = (m_owner == 1) ? 2'b10 : 2'b01;
                e_q      = 4'd0;
                e_busy   = 1'b1;
            end else begin
                e_gnt  = 2'b00;
                e_busy = 1'b0;
            end
        end else begin
            m_j++;
            if (m_j <= m_tgt + 1 && !req[m_owner]) begin
                e_q = 4'd0;
                finish_run();
            end else if (m_j <= m_tgt) begin
                e_q = 4'(m_j);
            end else if (m_j == m_tgt + 1) begin
                e_done = (m_owner == 1) ? 2'b10 : 2'b01;
            end else begin
                finish_run();
            end
        end
        #1;
        chk("gnt",  int'(gnt),  int'(e_gnt));
        chk("q",    int'(q),    int'(e_q));
        chk("done", int'(done), int'(e_done));
        chk("busy", int'(busy), int'(e_busy));
        chk("onehot_gnt",  int'(gnt != 2'b11),  1);
        chk("onehot_done", int'(done != 2'b11), 1);
    end

    task automatic negs(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        negs(2);
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0; req = 2'b00; tgt0 = 4'd0; tgt1 = 4'd0;
        #2;
        chk("reset_q",    int'(q),    0);
        chk("reset_gnt",  int'(gnt),  0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        negs(1);
        rst = 1'b1;

        // Single run, target 5.
        req = 2'b01; tgt0 = 4'd5;
        negs(1);
        chk("single_gnt", int'(gnt), 1);
        chk("single_q0",  int'(q),   0);
        negs(5);
        chk("single_q5",    int'(q),    5);
        chk("single_nodone", int'(done), 0);
        negs(1);
        chk("single_done", int'(done), 1);
        req = 2'b00;
        negs(1);
        chk("single_idle_gnt",  int'(gnt),  0);
        chk("single_idle_busy", int'(busy), 0);

        // Contention from reset: requester 0 first, then requester 1.
        req = 2'b11; tgt0 = 4'd3; tgt1 = 4'd2;
        do_reset();
        negs(1);
        chk("cont_gnt0", int'(gnt), 1);
        negs(3);
        chk("cont_q3", int'(q), 3);
        negs(1);
        chk("cont_done0", int'(done), 1);
        negs(2);
        chk("cont_gnt1", int'(gnt), 2);
        chk("cont_q0",   int'(q),   0);
        negs(2);
        chk("cont_q2", int'(q), 2);
        negs(1);
        chk("cont_done1", int'(done), 2);
        req = 2'b00;
        negs(2);

        // Target 0, then target 15 with the request held through DONE.
        req = 2'b01; tgt0 = 4'd0;
        negs(1);
        chk("t0_gnt", int'(gnt), 1);
        negs(1);
        chk("t0_done", int'(done), 1);
        chk("t0_q",    int'(q),    0);
        tgt0 = 4'd15;
        negs(2);
        chk("t15_regrant", int'(gnt), 1);
        negs(15);
        chk("t15_q", int'(q), 15);
        negs(1);
        chk("t15_done",   int'(done), 1);
        chk("t15_nowrap", int'(q),    15);
        req = 2'b00;
        negs(2);

        // Abort at q=4 with requester 1 waiting.
        req = 2'b01; tgt0 = 4'd10;
        negs(5);
        chk("abort_q4", int'(q), 4);
        req = 2'b10; tgt1 = 4'd3;
        negs(1);
        chk("abort_q",    int'(q),    0);
        chk("abort_gnt",  int'(gnt),  0);
        chk("abort_done", int'(done), 0);
        negs(1);
        chk("abort_next_gnt", int'(gnt), 2);
        req = 2'b00;
        negs(2);

        // Asynchronous reset while q=7.
        req = 2'b01; tgt0 = 4'd12;
        negs(8);
        chk("areset_q7", int'(q), 7);
        #2 rst = 1'b0;
        #1;
        chk("areset_q",    int'(q),    0);
        chk("areset_gnt",  int'(gnt),  0);
        chk("areset_busy", int'(busy), 0);
        chk("areset_done", int'(done), 0);
        req = 2'b00;
        negs(2);
        rst = 1'b1;
        negs(1);

        // Target changed mid-run is ignored.
        req = 2'b01; tgt0 = 4'd6;
        negs(4);
        chk("tchg_q3", int'(q), 3);
        tgt0 = 4'd2;
        negs(3);
        chk("tchg_q6",    int'(q),    6);
        chk("tchg_nodone", int'(done), 0);
        negs(1);
        chk("tchg_done", int'(done), 1);
        req = 2'b00;
        negs(2);

        // Randomized phase: sticky requests with occasional flips, target churn.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 11) == 0) req[0] = ~req[0];
            if ($urandom_range(0, 11) == 0) req[1] = ~req[1];
            if ($urandom_range(0, 3) == 0) tgt0 = 4'($urandom_range(0, 15) >> $urandom_range(0, 2));
            if ($urandom_range(0, 3) == 0) tgt1 = 4'($urandom_range(0, 15) >> $urandom_range(0, 2));
            if ($urandom_range(0, 799) == 0) begin
                #3 rst = 1'b0;
                @(negedge clk);
                rst = 1'b1;
            end
        end

        negs(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
